matrix_op_sequencer: RTL and testbench
======================================

Name: matrix_op_sequencer

Overview:
- Sits directly downstream of the keypad opcode encoder.
- Consumes the encoder's 3-bit opcode and its is_op level, detects a new operation request, latches the opcode, and walks every element of two operand matrices through an element ALU. Results are written back to the result matrix store.
- Completion, overflow and illegal-opcode status go to the display/control logic.

Parameters:
- ROWS, 3, matrix row count.
- COLS, 3, matrix column count.
- DW, 8, element width in bits (unsigned).
- AW, $clog2(ROWS*COLS), element address width (derived; do not override).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- op_in  input  3  opcode from the encoder: 3'b001 add, 3'b010 subtract; all other codes illegal
- is_op  input  1  level from the encoder, high while an operation key is held
- rd_addr  output  AW  element index presented to both operand stores
- rd_en  output  1  read strobe; operand data is valid exactly one cycle later
- a_data  input  DW  matrix A element (1-cycle read latency)
- b_data  input  DW  matrix B element (1-cycle read latency)
- wr_en  output  1  result write strobe
- wr_addr  output  AW  result element index
- wr_data  output  DW  result element
- busy  output  1  high from the first RUN cycle through the DONE cycle
- done  output  1  one-cycle pulse when the last result is written
- overflow  output  1  sticky per operation: any carry-out (add) or borrow (subtract) seen
- err  output  1  one-cycle pulse when an illegal opcode is triggered

Behaviour:
- Reset, checked before all other logic: state=IDLE, index=0, and every output is 0, including overflow.
- Trigger: the rising edge of is_op (is_op=1 this cycle, registered is_op=0 last cycle). Call that cycle T.
- Only a trigger seen in IDLE is acted on. Triggers while busy are dropped, with no queue and no err.
- Holding is_op high never retriggers. A new trigger needs is_op low for at least one cycle.
- Illegal opcode at trigger: stay IDLE and pulse err at T+1. No reads or writes; overflow unchanged.
- Legal opcode at T:
  - latch the opcode;
  - clear overflow;
  - go to RUN at T+1.
- States:
  - IDLE: wait for a legal trigger.
  - RUN: issue reads k=0..N-1, where N=ROWS*COLS.
  - LAST: the final write cycle, no read.
  - Then back to IDLE.
- Timing:
  - Read k (rd_en=1, rd_addr=k) occurs at cycle T+1+k.
  - Write k (wr_en=1, wr_addr=k) occurs at cycle T+2+k.
  - Read and write overlap in every RUN cycle after the first.
  - The final write is at T+N+1; done pulses in that same cycle.
  - busy is high over T+1..T+N+1, and state is IDLE at T+N+2.
  - Total latency from trigger to done is N+1 cycles.
- Arithmetic:
  - wr_data = (a+b) mod 2^DW for add, (a−b) mod 2^DW for subtract.
  - overflow sets on carry-out (add) or a<b (subtract) for any element. It holds until the next legal trigger or rst.
- rd_addr, wr_addr and wr_data hold their last values when the matching strobe is low. Verification checks them only while the strobe is high.
- Index wrap: the counter stops at N-1; it never wraps to 0 within an operation.
- rst mid-operation takes effect the next edge: IDLE, all outputs 0, and no further reads or writes. An is_op still held high does not retrigger until it has been low.
- op_in changing after T has no effect on the current operation.

Decomposition:
- Package matrix_pkg holds:
  - op_t enum: OP_NONE=3'b000, OP_ADD=3'b001, OP_SUB=3'b010;
  - seq_state_t enum: IDLE, RUN, LAST;
  - default ROWS/COLS/DW constants, shared with the encoder and the matrix stores.
- One sub-module, elem_alu (combinational): inputs op, a, b; outputs result[DW-1:0] and carry_borrow.
- matrix_op_sequencer owns edge detection, the FSM, the index counter, the write-pipeline register and the sticky flag.

Test Plan (defaults N=9, DW=8):
- Add: A[k]=k, B[k]=10. Raise is_op with op_in=001 at T. Expect reads at T+1..T+9, writes at T+2..T+10 with wr_data=10..18, done only at T+10, overflow=0, busy low at T+11.
- Subtract with borrow: A[k]=5, B[k]=k. Trigger op_in=010. Expect wr_data 5,4,3,2,1,0,255,254,253, overflow=1 from then until the next trigger, done at T+10.
- Add overflow clears: A[k]=200, B[k]=100 gives wr_data=44 and overflow=1. A following legal add with small values ends with overflow=0.
- Illegal opcode: op_in=011 with an is_op edge. Expect err=1 at T+1 only, no rd_en/wr_en, busy=0.
- Retrigger and hold: an is_op edge at T+4 during an operation is ignored (exactly 9 writes). is_op held high for 30 cycles gives exactly one operation.
- Reset mid-operation: assert rst at T+5 for 1 cycle. The next cycle has all outputs 0 and state IDLE, with no writes afterwards. A later clean trigger gives a full 9-write operation.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared types and default geometry for the matrix datapath: the keypad
// encoder, the matrix stores and the operation sequencer all import this.
package matrix_pkg;

  localparam int ROWS_DEF = 3;
  localparam int COLS_DEF = 3;
  localparam int DW_DEF   = 8;

  typedef enum logic [2:0] {
    OP_NONE = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAST = 2'd2
  } seq_state_t;

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/matrix_op_sequencer_elem_alu.sv
// Combinational element ALU: modular add/subtract of one unsigned element
// pair, with carry-out (add) or borrow (subtract) reported separately.
module elem_alu
  import matrix_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [2:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] result,
  output logic          carry_borrow
);

  // Element arithmetic; unknown opcodes produce zero with no flag.
  always_comb begin
    result       = {DW{1'b0}};
    carry_borrow = 1'b0;
    case (op)
      OP_ADD: begin
        {carry_borrow, result} = {1'b0, a} + {1'b0, b};
      end
      OP_SUB: begin
        result       = a - b;
        carry_borrow = (a < b);
      end
      default: begin
        result       = {DW{1'b0}};
        carry_borrow = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/matrix_op_sequencer.sv
// Walks every element of matrices A and B through the element ALU after a
// keypad operation edge, streaming results into the result store.
module matrix_op_sequencer
  import matrix_pkg::*;
#(
  parameter  int ROWS = ROWS_DEF,
  parameter  int COLS = COLS_DEF,
  parameter  int DW   = DW_DEF,
  localparam int AW   = $clog2(ROWS * COLS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    op_in,
  input  logic          is_op,
  output logic [AW-1:0] rd_addr,
  output logic          rd_en,
  input  logic [DW-1:0] a_data,
  input  logic [DW-1:0] b_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          busy,
  output logic          done,
  output logic          overflow,
  output logic          err
);

  localparam int            N        = ROWS * COLS;
  localparam logic [AW-1:0] IDX_LAST = AW'(N - 1);

  seq_state_t    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  op_t           op_q, op_d;
  logic          is_op_q;
  logic          rd_en_q, rd_en_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_hold_q, wr_hold_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          ovf_q, ovf_d;

  logic          trig_s;
  logic [DW-1:0] alu_res_s;
  logic          alu_cb_s;

  // Operand data returns one cycle after the read, so the ALU sees the
  // element whose write strobe is currently asserted.
  elem_alu #(
    .DW (DW)
  ) u_alu (
    .op           (op_q),
    .a            (a_data),
    .b            (b_data),
    .result       (alu_res_s),
    .carry_borrow (alu_cb_s)
  );

  assign trig_s = is_op & ~is_op_q;

  // Next-state, index, sticky flag and output pipeline.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    op_d    = op_q;
    err_d   = 1'b0;
    if (wr_en_q && alu_cb_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
    case (state_q)
      IDLE: begin
        if (trig_s) begin
          if (op_is_legal(op_in)) begin
            state_d = RUN;
            idx_d   = {AW{1'b0}};
            op_d    = op_t'(op_in);
            ovf_d   = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // Index saturates at the last element; LAST drains the final write.
        if (idx_q == IDX_LAST) begin
          state_d = LAST;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      LAST: begin
        state_d = IDLE;
        idx_d   = {AW{1'b0}};
      end
      default: begin
        state_d = IDLE;
        idx_d   = {AW{1'b0}};
      end
    endcase

    rd_en_d   = (state_d == RUN);
    rd_addr_d = rd_en_d ? idx_d : rd_addr_q;
    wr_en_d   = rd_en_q;
    wr_addr_d = rd_en_q ? rd_addr_q : wr_addr_q;
    wr_hold_d = wr_en_q ? alu_res_s : wr_hold_q;
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == LAST);
  end

  // State and output registers; reset also arms the edge detector high so
  // a key held through reset must be released before it can trigger.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= {AW{1'b0}};
      op_q      <= OP_NONE;
      is_op_q   <= 1'b1;
      rd_en_q   <= 1'b0;
      rd_addr_q <= {AW{1'b0}};
      wr_en_q   <= 1'b0;
      wr_addr_q <= {AW{1'b0}};
      wr_hold_q <= {DW{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      op_q      <= op_d;
      is_op_q   <= is_op;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_hold_q <= wr_hold_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ovf_q     <= ovf_d;
    end
  end

  assign rd_en    = rd_en_q;
  assign rd_addr  = rd_addr_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_en_q ? alu_res_s : wr_hold_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = ovf_q;
  assign err      = err_q;

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// Scoreboard bench for matrix_op_sequencer with the default 3x3, 8-bit geometry.
module tb_matrix_op_sequencer;

  localparam int N = 9;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] op_in = 3'b000;
  logic       is_op = 1'b0;
  logic [3:0] rd_addr, wr_addr;
  logic       rd_en, wr_en, busy, done, overflow, err;
  logic [7:0] a_data = 8'd0;
  logic [7:0] b_data = 8'd0;
  logic [7:0] wr_data;
  logic [7:0] a_mem [16];
  logic [7:0] b_mem [16];

  wr_t exp_q[$];
  wr_t obs_q[$];
  int  total = 0;
  int  bad = 0;
  int  done_cnt = 0;
  int  rd_cnt = 0;
  int  err_cnt = 0;

  always #5 clk = ~clk;

  matrix_op_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .op_in    (op_in),
    .is_op    (is_op),
    .rd_addr  (rd_addr),
    .rd_en    (rd_en),
    .a_data   (a_data),
    .b_data   (b_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .err      (err)
  );

  // Operand stores with one-cycle read latency
  always @(posedge clk) begin
    if (rd_en) begin
      a_data <= a_mem[rd_addr];
      b_data <= b_mem[rd_addr];
    end
  end

  // Output monitor: records writes and counts strobes
  always @(negedge clk) begin
    if (wr_en) obs_q.push_back({wr_addr, wr_data});
    if (done) done_cnt++;
    if (rd_en) rd_cnt++;
    if (err) err_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fire(input logic [2:0] op);
    op_in = op;
    is_op = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({rd_en, wr_en, busy, done, overflow, err, rd_addr, wr_addr, wr_data} !== 22'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%b exp=0", {rd_en, wr_en, busy, done, overflow, err, rd_addr, wr_addr, wr_data});
    end
  endtask

  task automatic test_add();
    logic [3:0] exp_v;
    wr_t o, e;
    for (int k = 0; k < N; k++) begin
      a_mem[k] = 8'(k);
      b_mem[k] = 8'd10;
      exp_q.push_back({4'(k), 8'(k + 10)});
    end
    tick();
    fire(3'b001);
    for (int c = 1; c <= 11; c++) begin
      tick();
      if (c == 1) is_op = 1'b0;
      if (c == 2) op_in = 3'b010;
      @(negedge clk);
      exp_v[3] = (c <= 9);
      exp_v[2] = (c >= 2) && (c <= 10);
      exp_v[1] = (c <= 10);
      exp_v[0] = (c == 10);
      total++;
      if ({rd_en, wr_en, busy, done} !== exp_v) begin
        bad++;
        $display("FAIL add_timing cycle=T+%0d rd/wr/busy/done got=%b exp=%b", c, {rd_en, wr_en, busy, done}, exp_v);
      end
      if (c <= 9) begin
        total++;
        if (rd_addr !== 4'(c - 1)) begin
          bad++;
          $display("FAIL add_rd_addr cycle=T+%0d got=%0d exp=%0d", c, rd_addr, c - 1);
        end
      end
    end
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL add_overflow got=%b exp=0", overflow);
    end
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL add_write_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL add_write got=%0d:%0d exp=%0d:%0d", o.addr, o.data, e.addr, e.data);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_sub_borrow();
    int  d0;
    wr_t o, e;
    for (int k = 0; k < N; k++) begin
      a_mem[k] = 8'd5;
      b_mem[k] = 8'(k);
      exp_q.push_back({4'(k), 8'(5 - k)});
    end
    d0 = done_cnt;
    tick();
    fire(3'b010);
    for (int c = 1; c <= 11; c++) begin
      tick();
      if (c == 1) is_op = 1'b0;
      @(negedge clk);
      if (c == 10) begin
        total++;
        if (done !== 1'b1) begin
          bad++;
          $display("FAIL sub_done_at_T+10 got=%b exp=1", done);
        end
      end
    end
    repeat (5) tick();
    total++;
    if (overflow !== 1'b1 || done_cnt - d0 != 1) begin
      bad++;
      $display("FAIL sub_overflow_done got=%b/%0d exp=1/1", overflow, done_cnt - d0);
    end
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL sub_write_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL sub_write got=%0d:%0d exp=%0d:%0d", o.addr, o.data, e.addr, e.data);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_illegal();
    int r0, e0;
    r0 = rd_cnt;
    e0 = err_cnt;
    tick();
    fire(3'b011);
    tick();
    is_op = 1'b0;
    @(negedge clk);
    total++;
    if ({err, rd_en, wr_en, busy} !== 4'b1000) begin
      bad++;
      $display("FAIL illegal_T+1 err/rd/wr/busy got=%b exp=1000", {err, rd_en, wr_en, busy});
    end
    tick();
    @(negedge clk);
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL illegal_err_width got=%b exp=0", err);
    end
    repeat (4) tick();
    total++;
    if (obs_q.size() != 0 || rd_cnt != r0 || err_cnt - e0 != 1 || overflow !== 1'b1) begin
      bad++;
      $display("FAIL illegal_side_effects writes=%0d reads=%0d errs=%0d ovf=%b exp=0/0/1/1",
               obs_q.size(), rd_cnt - r0, err_cnt - e0, overflow);
    end
    obs_q.delete();
  endtask

  task automatic test_ovf_clear();
    wr_t o, e;
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < N; k++) begin
        a_mem[k] = (pass == 0) ? 8'd200 : 8'(k);
        b_mem[k] = (pass == 0) ? 8'd100 : 8'd1;
        exp_q.push_back({4'(k), (pass == 0) ? 8'd44 : 8'(k + 1)});
      end
      tick();
      fire(3'b001);
      for (int c = 1; c <= 11; c++) begin
        tick();
        if (c == 1) is_op = 1'b0;
        @(negedge clk);
        if (c == 1 && pass == 1) begin
          total++;
          if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL ovf_cleared_on_trigger got=%b exp=0", overflow);
          end
        end
      end
      total++;
      if (overflow !== ((pass == 0) ? 1'b1 : 1'b0)) begin
        bad++;
        $display("FAIL ovf_pass%0d got=%b exp=%b", pass, overflow, (pass == 0));
      end
      total++;
      if (obs_q.size() != exp_q.size()) begin
        bad++;
        $display("FAIL ovf_write_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
        o = obs_q.pop_front();
        e = exp_q.pop_front();
        total++;
        if (o !== e) begin
          bad++;
          $display("FAIL ovf_write got=%0d:%0d exp=%0d:%0d", o.addr, o.data, e.addr, e.data);
        end
      end
      exp_q.delete();
      obs_q.delete();
    end
  endtask

  task automatic test_retrigger_hold();
    int d0, e0, r0;
    for (int k = 0; k < N; k++) begin
      a_mem[k] = 8'(k);
      b_mem[k] = 8'(2 * k);
    end
    for (int pass = 0; pass < 2; pass++) begin
      d0 = done_cnt;
      e0 = err_cnt;
      r0 = rd_cnt;
      tick();
      fire(3'b001);
      if (pass == 0) begin
        for (int c = 1; c <= 14; c++) begin
          tick();
          if (c == 1) is_op = 1'b0;
          if (c == 4) fire(3'b011);
          if (c == 6) is_op = 1'b0;
        end
      end else begin
        repeat (30) tick();
        is_op = 1'b0;
        repeat (3) tick();
      end
      total++;
      if (obs_q.size() != N || done_cnt - d0 != 1 || rd_cnt - r0 != N || err_cnt != e0) begin
        bad++;
        $display("FAIL retrigger_pass%0d writes=%0d dones=%0d reads=%0d errs=%0d exp=9/1/9/0",
                 pass, obs_q.size(), done_cnt - d0, rd_cnt - r0, err_cnt - e0);
      end
      for (int k = 0; k < N && obs_q.size() > 0; k++) begin
        wr_t o;
        o = obs_q.pop_front();
        total++;
        if (o !== {4'(k), 8'(3 * k)}) begin
          bad++;
          $display("FAIL retrigger_write got=%0d:%0d exp=%0d:%0d", o.addr, o.data, k, 3 * k);
        end
      end
      obs_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    int  d0;
    wr_t o, e;
    for (int k = 0; k < N; k++) begin
      a_mem[k] = 8'(k);
      b_mem[k] = 8'd1;
    end
    for (int k = 0; k < 4; k++) exp_q.push_back({4'(k), 8'(k + 1)});
    tick();
    fire(3'b001);
    for (int c = 1; c <= 5; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({rd_en, wr_en, busy, done, overflow, err, rd_addr, wr_addr, wr_data} !== 22'd0) begin
      bad++;
      $display("FAIL midreset_outputs got=%b exp=0", {rd_en, wr_en, busy, done, overflow, err, rd_addr, wr_addr, wr_data});
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      @(negedge clk);
      total++;
      if ({rd_en, wr_en, busy} !== 3'b000) begin
        bad++;
        $display("FAIL midreset_held_key cycle=%0d rd/wr/busy got=%b exp=000", c, {rd_en, wr_en, busy});
      end
    end
    is_op = 1'b0;
    tick();
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL midreset_write_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL midreset_write got=%0d:%0d exp=%0d:%0d", o.addr, o.data, e.addr, e.data);
      end
    end
    exp_q.delete();
    obs_q.delete();
    d0 = done_cnt;
    tick();
    fire(3'b001);
    tick();
    is_op = 1'b0;
    repeat (12) tick();
    total++;
    if (obs_q.size() != N || done_cnt - d0 != 1) begin
      bad++;
      $display("FAIL midreset_recover writes=%0d dones=%0d exp=9/1", obs_q.size(), done_cnt - d0);
    end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      total++;
      if (o.data !== 8'(o.addr + 1)) begin
        bad++;
        $display("FAIL midreset_recover_data addr=%0d got=%0d exp=%0d", o.addr, o.data, o.addr + 1);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 16; k++) begin
      a_mem[k] = 8'd0;
      b_mem[k] = 8'd0;
    end
    test_reset();
    test_add();
    test_sub_borrow();
    test_illegal();
    test_ovf_clear();
    test_retrigger_hold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
